// File: rtl/imem_pkg.sv
// Shared fetch-interface definitions: instruction memory base address,
// the response record carried through the responder, and the zero word.
package imem_pkg;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] ZERO_INST      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } fetch_rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO of fetch responses; pointers carry an extra MSB so that
// full and empty are distinguished without a separate count.
module resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_rsp_t din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output fetch_rsp_t dout
);

  localparam int AW = $clog2(DEPTH);

  fetch_rsp_t   store [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = store[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr[AW-1:0]] <= din;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word RAM with a side load port, a fixed
// LATENCY delay line and a credit-limited in-order response queue.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = IMEM_BASE_ADDR,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1,
  parameter int          OUTQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int CNT_W = $clog2(OUTQ_DEPTH + 1);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic                  run_q;
  logic [CNT_W-1:0]      outstanding;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  below;
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  err;
  logic [31:0]           inst_p [LATENCY];
  logic                  err_p  [LATENCY];
  logic [LATENCY-1:0]    vld_p;
  fetch_rsp_t            q_din;
  fetch_rsp_t            q_dout;
  logic                  q_full;
  logic                  q_empty;

  // Offset is forced to zero below the base so the subtraction cannot wrap
  // back into range; BASE_ADDR is word aligned, so off[1:0] == req_addr[1:0].
  always_comb begin
    below = (req_addr < BASE_ADDR);
    off   = below ? '0 : (req_addr - BASE_ADDR);
    idx   = off[DEPTH_LOG2+1:2];
    err   = below | (|off[1:0]) | (|off[31:DEPTH_LOG2+2]);
  end

  assign req_ready = run_q && (outstanding < CNT_W'(OUTQ_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !q_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_inst  = q_empty ? ZERO_INST : q_dout.inst;
  assign rsp_err   = !q_empty && q_dout.err;

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      outstanding <= '0;
    end else begin
      run_q <= 1'b1;
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ---- stage p0: RAM read at the accept edge, then LATENCY-1 more stages ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    inst_p[0] <= mem[idx];
    err_p[0]  <= err;
    for (int i = 1; i < LATENCY; i++) begin
      inst_p[i] <= inst_p[i-1];
      err_p[i]  <= err_p[i-1];
    end
  end

  // ---- last delay stage feeds the response queue ----
  assign push       = vld_p[LATENCY-1];
  assign q_din.inst = err_p[LATENCY-1] ? ZERO_INST : inst_p[LATENCY-1];
  assign q_din.err  = err_p[LATENCY-1];

  resp_fifo #(.DEPTH(OUTQ_DEPTH)) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .full  (q_full),
    .empty (q_empty),
    .dout  (q_dout)
  );

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst) outstanding <= CNT_W'(OUTQ_DEPTH));
  a_push_room:    assert property (@(posedge clk) disable iff (!rst) !(push && q_full && !pop));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: directed fetches push expected
// responses; a negedge monitor pops and compares on every response handshake.
module tb_imem_fetch_responder;

  localparam int LAT = 1;
  localparam int DL2 = 12;
  localparam int QD  = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] WORD_A = 32'h1111_5555;
  localparam logic [31:0] WORD_B = 32'h2222_5555;
  localparam logic [31:0] LAST_W = 32'hDEAD_BEEF;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [31:0]    req_addr = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [31:0]    rsp_inst;
  logic           rsp_err;
  logic           load_en = 1'b0;
  logic [DL2-1:0] load_addr = '0;
  logic [31:0]    load_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [32:0] exp_q [$];
  int          hs_cyc [$];

  logic [31:0] ram_init [8] = '{32'h0000_0297, 32'h0282_8293, 32'h0003_2303, 32'h0062_8333,
                                32'h0000_0013, WORD_A,        32'h00C0_006F, 32'hFFDF_F06F};

  imem_fetch_responder #(
    .BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .LATENCY(LAT), .OUTQ_DEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: every response handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_rsp", 33'(rsp_valid), 33'h0);
      else chk("rsp", {rsp_inst, rsp_err}, exp_q.pop_front());
    end
  end

  task automatic issue(input logic [31:0] a, input logic [32:0] e);
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    timeout_fail("req_accept");
  endtask

  task automatic load_word(input logic [DL2-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      timeout_fail("drain");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 33'(req_ready), 33'h0);
    chk("reset_rsp_valid", 33'(rsp_valid), 33'h0);
    chk("reset_rsp_inst",  33'(rsp_inst),  33'h0);
    chk("reset_rsp_err",   33'(rsp_err),   33'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 33'(req_ready), 33'h1);

    for (int k = 0; k < 8; k++) load_word(DL2'(k), ram_init[k]);
    load_word(DL2'(4095), LAST_W);

    // Boot fetch and latency
    rsp_ready = 1'b1;
    issue(BASE, {32'h0000_0297, 1'b0});
    for (int i = 0; i < LAT; i++) begin
      chk("boot_latency_low", 33'(rsp_valid), 33'h0);
      @(posedge clk); #1;
    end
    chk("boot_latency_high", 33'(rsp_valid), 33'h1);
    wait_drain();

    // Streaming back to back
    hs_cyc.delete();
    for (int k = 0; k < 8; k++) issue(BASE + 32'(4 * k), {ram_init[k], 1'b0});
    wait_drain();
    chk("stream_count", 33'(hs_cyc.size()), 33'd8);
    if (hs_cyc.size() == 8) chk("stream_span", 33'(hs_cyc[7] - hs_cyc[0]), 33'd7);

    // Backpressure
    rsp_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 6; t++) begin
      req_valid = 1'b1;
      req_addr  = BASE + 32'(4 * acc);
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({ram_init[acc], 1'b0});
        acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 33'(acc), 33'd4);
    @(negedge clk);
    chk("bp_ready_low", 33'(req_ready), 33'h0);
    rsp_ready = 1'b1;
    wait_drain();
    chk("bp_ready_back", 33'(req_ready), 33'h1);

    // Error decode and range boundaries
    issue(32'h8000_0002, {32'h0, 1'b1});
    issue(32'h7FFF_FFFC, {32'h0, 1'b1});
    issue(32'h8000_4000, {32'h0, 1'b1});
    issue(32'hFFFF_FFFC, {32'h0, 1'b1});
    issue(32'h8000_3FFC, {LAST_W, 1'b0});
    wait_drain();

    // Load/fetch collision returns pre-write data
    load_en = 1'b1; load_addr = DL2'(5); load_data = WORD_B;
    issue(32'h8000_0014, {WORD_A, 1'b0});
    load_en = 1'b0;
    issue(32'h8000_0014, {WORD_B, 1'b0});
    wait_drain();

    // Reset with responses in flight
    rsp_ready = 1'b0;
    issue(BASE,                {ram_init[0], 1'b0});
    issue(BASE + 32'h4,        {ram_init[1], 1'b0});
    issue(BASE + 32'h8,        {ram_init[2], 1'b0});
    chk("inflight_valid", 33'(rsp_valid), 33'h1);
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    chk("rst_drops_valid", 33'(rsp_valid), 33'h0);
    chk("rst_ready_low",   33'(req_ready), 33'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midreset", 33'(req_ready), 33'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_spurious_valid", 33'(rsp_valid), 33'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
